// File: rtl/retro16_pkg.sv
// Shared retro16 definitions: word width, reset PC, fetch FSM state type.
// FETCH_PREFETCH_EN selects a 2-entry fetch buffer; otherwise 1 entry.
package retro16_pkg;

  localparam int unsigned WORD_W = 16;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned FETCH_DEPTH = 2;
`else
  localparam int unsigned FETCH_DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_REQ,
    ST_WAIT,
    ST_FULL
  } fetch_state_t;

  function automatic logic [WORD_W-1:0] pc_next(input logic [WORD_W-1:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small in-order instruction buffer (depth 1 or 2) with push/pop/flush.
module fetch_buffer
  import retro16_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  logic [WORD_W-1:0] slot [2];

  assign head  = slot[0];
  assign full  = (count == DEPTH_C);
  assign empty = (count == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot[0] <= '0;
      slot[1] <= '0;
      count   <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!full) begin
            slot[count[0]] <= wdata;
            count          <= count + 2'd1;
          end
        end
        2'b01: begin
          slot[0] <= slot[1];
          count   <= count - 2'd1;
        end
        2'b11: begin
          // Shift the head out, then write the new word into the last
          // occupied slot; the later assignment wins when both hit slot 0.
          slot[0]        <= slot[1];
          slot[count[1]] <= wdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: drives the PC write port and instruction reads.
// FETCH_PREFETCH_EN enables a 2-deep prefetch buffer (default is 1 deep).
module instruction_fetch
  import retro16_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] pc_in,
  output logic [WORD_W-1:0] pc_out,
  output logic              pc_write_en,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] instr_out,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam logic [1:0] DEPTH_C = 2'(FETCH_DEPTH);

  fetch_state_t      state;
  logic              discard;
  logic              wr_defer;
  logic              push;
  logic              pop;
  logic              buf_full;
  logic              buf_empty;
  logic [1:0]        buf_count;
  logic              room_after;
  logic [WORD_W-1:0] cur_pc;
  logic              pc_evt;
  logic [WORD_W-1:0] pc_evt_val;

  // pc_in lags a PC write by one edge, so a pending write is forwarded.
  assign cur_pc      = (pc_write_en | wr_defer) ? pc_out : pc_in;
  assign pop         = instr_valid & instr_ready;
  assign push        = (state == ST_WAIT) & mem_ack & ~discard & ~redirect & ~buf_full;
  assign instr_valid = ~buf_empty;
  assign room_after  = pop | ((buf_count + 2'd1) < DEPTH_C);

  always_comb begin
    pc_evt     = 1'b0;
    pc_evt_val = '0;
    if (redirect) begin
      pc_evt     = 1'b1;
      pc_evt_val = redirect_pc;
    end else if (state == ST_BOOT) begin
      pc_evt     = 1'b1;
      pc_evt_val = RESET_PC;
    end else if (push) begin
      pc_evt     = 1'b1;
      pc_evt_val = pc_next(cur_pc);
    end
  end

  fetch_buffer #(
    .DEPTH(FETCH_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (mem_rdata),
    .head  (instr_out),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  // A PC update landing right after a strobe is held one cycle so the
  // strobe never repeats back to back; the newest value always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out      <= '0;
      pc_write_en <= 1'b0;
      wr_defer    <= 1'b0;
    end else if (pc_evt) begin
      pc_out      <= pc_evt_val;
      pc_write_en <= ~pc_write_en;
      wr_defer    <= pc_write_en;
    end else begin
      pc_write_en <= wr_defer;
      wr_defer    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      discard  <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (redirect) begin
      if (state == ST_WAIT && !mem_ack) begin
        discard <= 1'b1;
      end else begin
        state   <= ST_REQ;
        discard <= 1'b0;
        mem_req <= 1'b0;
      end
    end else begin
      case (state)
        ST_BOOT: state <= ST_REQ;
        ST_REQ: begin
          mem_req  <= 1'b1;
          mem_addr <= cur_pc;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (discard) begin
              discard <= 1'b0;
              state   <= ST_REQ;
            end else begin
              state <= room_after ? ST_REQ : ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (pop) state <= ST_REQ;
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a one-register PC file model.
module tb_instruction_fetch;

`ifdef FETCH_PREFETCH_EN
  localparam int EXP_DEPTH = 2;
`else
  localparam int EXP_DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_in;
  logic [15:0] pc_out;
  logic        pc_write_en;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC(16'h0100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_in       (pc_in),
    .pc_out      (pc_out),
    .pc_write_en (pc_write_en),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  // Register-file PC: latches pc_out on a strobe
  always @(posedge clk) if (pc_write_en) pc_in <= pc_out;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 10 && mem_req !== 1'b1; i++) step();
    check(tag, {15'd0, mem_req}, 16'd1);
  endtask

  logic pcwe_prev = 1'b0;
  always @(negedge clk) begin
    if (pcwe_prev) check("pcwe_gap", {15'd0, pc_write_en}, 16'd0);
    pcwe_prev = pc_write_en;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_words [2];
    int offers;
    exp_words[0] = 16'h7777;
    exp_words[1] = 16'h1111;

    rst_n = 1'b0; pc_in = 16'h0000; mem_ack = 1'b0; mem_rdata = 16'h0000;
    redirect = 1'b0; redirect_pc = 16'h0000; instr_ready = 1'b0;
    step(); step();
    check("rst_pcwe",  {15'd0, pc_write_en}, 16'd0);
    check("rst_pcout", pc_out, 16'h0000);
    check("rst_req",   {15'd0, mem_req}, 16'd0);
    check("rst_addr",  mem_addr, 16'h0000);
    check("rst_valid", {15'd0, instr_valid}, 16'd0);
    check("rst_instr", instr_out, 16'h0000);

    // Boot sequence
    rst_n = 1'b1;
    step();
    check("boot_pcwe",  {15'd0, pc_write_en}, 16'd1);
    check("boot_pcout", pc_out, 16'h0100);
    step();
    check("boot_req",   {15'd0, mem_req}, 16'd1);
    check("boot_addr",  mem_addr, 16'h0100);
    check("boot_pcwe0", {15'd0, pc_write_en}, 16'd0);
    step();
    check("wait_hold_req",  {15'd0, mem_req}, 16'd1);
    check("wait_hold_addr", mem_addr, 16'h0100);

    // First fetch
    mem_ack = 1'b1; mem_rdata = 16'hA5A5; instr_ready = 1'b1;
    step();
    mem_ack = 1'b0;
    check("f1_valid", {15'd0, instr_valid}, 16'd1);
    check("f1_instr", instr_out, 16'hA5A5);
    check("f1_pcwe",  {15'd0, pc_write_en}, 16'd1);
    check("f1_pcout", pc_out, 16'h0101);
    check("f1_req0",  {15'd0, mem_req}, 16'd0);
    step();
    check("f1_popped", {15'd0, instr_valid}, 16'd0);
    wait_req("f2_req");
    check("f2_addr", mem_addr, 16'h0101);

    // Redirect during WAIT, then the stale word arrives
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    check("rd_pcwe",  {15'd0, pc_write_en}, 16'd1);
    check("rd_pcout", pc_out, 16'h0040);
    check("rd_hold",  {15'd0, mem_req}, 16'd1);
    check("rd_addr",  mem_addr, 16'h0101);
    step();
    check("rd_still", {15'd0, mem_req}, 16'd1);
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    step();
    mem_ack = 1'b0;
    check("drop_valid", {15'd0, instr_valid}, 16'd0);
    check("drop_pcwe",  {15'd0, pc_write_en}, 16'd0);
    check("drop_pcout", pc_out, 16'h0040);
    wait_req("rd_req");
    check("rd_newaddr", mem_addr, 16'h0040);
    check("drop_never", {15'd0, instr_valid}, 16'd0);

    // Redirect coincident with ack: redirect wins
    redirect = 1'b1; redirect_pc = 16'hFFFF; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    redirect = 1'b0; mem_ack = 1'b0;
    check("rdack_valid", {15'd0, instr_valid}, 16'd0);
    check("rdack_pcout", pc_out, 16'hFFFF);
    check("rdack_req",   {15'd0, mem_req}, 16'd0);
    wait_req("wrap_req");
    check("wrap_addr", mem_addr, 16'hFFFF);

    // Fetch at FFFF wraps the PC; decode stalled
    instr_ready = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    step();
    mem_ack = 1'b0;
    check("wrap_pcout", pc_out, 16'h0000);
    check("wrap_pcwe",  {15'd0, pc_write_en}, 16'd1);
    check("wrap_instr", instr_out, 16'h7777);

    // Offer acks while decode is stalled; fetching must stop when full
    offers = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req && offers < 3) begin
        offers++;
        mem_ack = 1'b1;
        mem_rdata = 16'h1111 * offers[15:0];
      end else begin
        mem_ack = 1'b0;
      end
      step();
    end
    mem_ack = 1'b0;
    check("stall_pushes", offers[15:0], 16'(EXP_DEPTH - 1));
    check("stall_req0",   {15'd0, mem_req}, 16'd0);

    // Release decode and drain in order
    instr_ready = 1'b1;
    for (int i = 0; i < EXP_DEPTH; i++) begin
      check("drain_valid", {15'd0, instr_valid}, 16'd1);
      check("drain_instr", instr_out, exp_words[i]);
      step();
    end
    check("drain_empty", {15'd0, instr_valid}, 16'd0);

    // Reset mid-WAIT with an ack during and just after reset
    wait_req("pre_rst_req");
    rst_n = 1'b0;
    #1;
    check("arst_req",   {15'd0, mem_req}, 16'd0);
    check("arst_addr",  mem_addr, 16'h0000);
    check("arst_pcwe",  {15'd0, pc_write_en}, 16'd0);
    check("arst_pcout", pc_out, 16'h0000);
    check("arst_valid", {15'd0, instr_valid}, 16'd0);
    check("arst_instr", instr_out, 16'h0000);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step(); step();
    rst_n = 1'b1;
    step();
    mem_ack = 1'b0;
    check("reboot_pcwe",  {15'd0, pc_write_en}, 16'd1);
    check("reboot_pcout", pc_out, 16'h0100);
    check("reboot_valid", {15'd0, instr_valid}, 16'd0);
    step();
    check("reboot_req",   {15'd0, mem_req}, 16'd1);
    check("reboot_addr",  mem_addr, 16'h0100);
    check("reboot_valid2", {15'd0, instr_valid}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
